// File: rtl/ula_controle_unit.sv
// MIPS ALU-control decoder: maps aluOp + funct to the ALU operation code, registered (1 cycle).
// Optional build macro ULA_CONTROLE_NOR_EN adds the R-type nor (funct 100111 -> 1100).
module ula_controle_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] aluOp,
  input  logic [5:0] operacao,
  output logic [3:0] controle,
  output logic       invalido
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ULA_CONTROLE_NOR_EN
  localparam logic [3:0] OP_NOR = 4'b1100;
`endif

  logic [3:0] controle_q, controle_d;
  logic       invalido_q, invalido_d;

  // No handshake: a fresh decode is sampled every rising edge and held until the next one.
  always_comb begin
    controle_d = OP_ADD;
    invalido_d = 1'b0;
    unique case (aluOp)
      2'b00: controle_d = OP_ADD;
      2'b01: controle_d = OP_SUB;
      2'b10: begin
        case (operacao)
          6'b100000: controle_d = OP_ADD;
          6'b100010: controle_d = OP_SUB;
          6'b100100: controle_d = OP_AND;
          6'b100101: controle_d = OP_OR;
          6'b101010: controle_d = OP_SLT;
`ifdef ULA_CONTROLE_NOR_EN
          6'b100111: controle_d = OP_NOR;
`endif
          default: begin
            controle_d = OP_ADD;
            invalido_d = 1'b1;
          end
        endcase
      end
      default: begin
        controle_d = OP_ADD;
        invalido_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      controle_q <= OP_ADD;
      invalido_q <= 1'b0;
    end else begin
      controle_q <= controle_d;
      invalido_q <= invalido_d;
    end
  end

  assign controle = controle_q;
  assign invalido = invalido_q;

endmodule

// File: tb/tb_ula_controle_unit.sv
// Self-checking bench for ula_controle_unit: expected {controle,invalido} pushed on drive,
// popped and compared one edge later.
module tb_ula_controle_unit;

  logic       clk;
  logic       rst;
  logic [1:0] aluOp;
  logic [5:0] operacao;
  logic [3:0] controle;
  logic       invalido;

  logic [4:0] exp_q[$];
  int checks;
  int errors;

  localparam logic [4:0] RST_V = 5'b0010_0;

  ula_controle_unit dut (
    .clk      (clk),
    .rst      (rst),
    .aluOp    (aluOp),
    .operacao (operacao),
    .controle (controle),
    .invalido (invalido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written from the opcode table, returns {controle, invalido}.
  function automatic logic [4:0] model(input logic [1:0] op, input logic [5:0] fn);
    logic [4:0] r;
    if (op == 2'b00) r = {4'b0010, 1'b0};
    else if (op == 2'b01) r = {4'b0110, 1'b0};
    else if (op == 2'b11) r = {4'b0010, 1'b1};
    else if (fn == 6'b100000) r = {4'b0010, 1'b0};
    else if (fn == 6'b100010) r = {4'b0110, 1'b0};
    else if (fn == 6'b100100) r = {4'b0000, 1'b0};
    else if (fn == 6'b100101) r = {4'b0001, 1'b0};
    else if (fn == 6'b101010) r = {4'b0111, 1'b0};
`ifdef ULA_CONTROLE_NOR_EN
    else if (fn == 6'b100111) r = {4'b1100, 1'b0};
`endif
    else r = {4'b0010, 1'b1};
    return r;
  endfunction

  // Apply inputs at the falling edge, record expectation, sample 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic [1:0] op, input logic [5:0] fn);
    @(negedge clk);
    rst = r;
    aluOp = op;
    operacao = fn;
    exp_q.push_back(r ? RST_V : model(op, fn));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
      e = exp_q.pop_front();
      checks++;
      if ({controle, invalido} !== e) begin
        errors++;
        $display("FAIL reset[%0d] got=%b_%b exp=%b_%b", i, controle, invalido, e[4:1], e[0]);
      end
    end
    drive(1'b0, 2'b01, 6'b000000);
    e = exp_q.pop_front();
    checks++;
    if ({controle, invalido} !== e) begin
      errors++;
      $display("FAIL reset_release got=%b_%b exp=%b_%b", controle, invalido, e[4:1], e[0]);
    end
  endtask

  task automatic test_load_branch();
    logic [1:0] ops [3];
    logic [5:0] fns [3];
    logic [4:0] e;
    ops[0] = 2'b00; fns[0] = 6'b000000;
    ops[1] = 2'b00; fns[1] = 6'b111111;
    ops[2] = 2'b01; fns[2] = 6'($urandom_range(0, 63));
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, ops[i], fns[i]);
      e = exp_q.pop_front();
      checks++;
      if ({controle, invalido} !== e) begin
        errors++;
        $display("FAIL load_branch op=%b fn=%b got=%b_%b exp=%b_%b",
                 ops[i], fns[i], controle, invalido, e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [5];
    logic [4:0] e;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b10, fns[i]);
      e = exp_q.pop_front();
      checks++;
      if ({controle, invalido} !== e) begin
        errors++;
        $display("FAIL rtype fn=%b got=%b_%b exp=%b_%b", fns[i], controle, invalido, e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [1:0] ops [4];
    logic [5:0] fns [4];
    logic [4:0] e;
    ops[0] = 2'b10; fns[0] = 6'b000000;
    ops[1] = 2'b11; fns[1] = 6'b100100;
    ops[2] = 2'b11; fns[2] = 6'b100000;
    ops[3] = 2'b10; fns[3] = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ops[i], fns[i]);
      e = exp_q.pop_front();
      checks++;
      if ({controle, invalido} !== e) begin
        errors++;
        $display("FAIL illegal op=%b fn=%b got=%b_%b exp=%b_%b",
                 ops[i], fns[i], controle, invalido, e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_nor();
    logic [4:0] e;
    drive(1'b0, 2'b10, 6'b100111);
    e = exp_q.pop_front();
    checks++;
    if ({controle, invalido} !== e) begin
      errors++;
      $display("FAIL nor_funct got=%b_%b exp=%b_%b", controle, invalido, e[4:1], e[0]);
    end
  endtask

  task automatic test_reset_midstream();
    logic [5:0] fns [5];
    logic [4:0] e;
    int k;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) drive(1'b1, 2'b10, 6'b101010);
      else begin
        drive(1'b0, 2'b10, fns[k]);
        k++;
      end
      e = exp_q.pop_front();
      checks++;
      if ({controle, invalido} !== e) begin
        errors++;
        $display("FAIL midreset step=%0d got=%b_%b exp=%b_%b", i, controle, invalido, e[4:1], e[0]);
      end
    end
  endtask

  // Outputs must not move when inputs change between edges.
  task automatic test_hold();
    logic [4:0] e;
    drive(1'b0, 2'b10, 6'b100100);
    e = exp_q.pop_front();
    @(negedge clk);
    aluOp = 2'b11;
    operacao = 6'b000001;
    exp_q.push_back(model(2'b11, 6'b000001));
    #2;
    checks++;
    if ({controle, invalido} !== e) begin
      errors++;
      $display("FAIL hold got=%b_%b exp=%b_%b", controle, invalido, e[4:1], e[0]);
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({controle, invalido} !== e) begin
      errors++;
      $display("FAIL hold_next got=%b_%b exp=%b_%b", controle, invalido, e[4:1], e[0]);
    end
  endtask

  task automatic test_random();
    logic [5:0] pool [7];
    logic [5:0] fn;
    logic [1:0] op;
    logic       r;
    logic [4:0] e;
    pool[0] = 6'b100000; pool[1] = 6'b100010; pool[2] = 6'b100100; pool[3] = 6'b100101;
    pool[4] = 6'b101010; pool[5] = 6'b100111; pool[6] = 6'b000000;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : pool[$urandom_range(0, 6)];
      r  = ($urandom_range(0, 15) == 0);
      drive(r, op, fn);
      e = exp_q.pop_front();
      checks++;
      if ({controle, invalido} !== e) begin
        errors++;
        $display("FAIL random[%0d] rst=%b op=%b fn=%b got=%b_%b exp=%b_%b",
                 i, r, op, fn, controle, invalido, e[4:1], e[0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    aluOp = 2'b00;
    operacao = 6'b000000;
    test_reset();
    test_load_branch();
    test_rtype();
    test_illegal();
    test_nor();
    test_reset_midstream();
    test_hold();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
